yc_niu_inj_arb: RTL and testbench
=================================

// Module: yc_niu_inj_arb
// PURPOSE
//  Round-robin injection arbiter sharing one router local (injection) port among NREQ NIU
//  traffic sources. Grants per packet: a winner owns the port from its first flit until its
//  req_last flit is accepted. Output stage is registered, so tx_* drives the router directly.
//  Lock watchdog and packet counter support bring-up. Sits between NIU sources and mesh router.
// PARAMETERS
//  NREQ          4    number of requesters (2..8)
//  LOCK_TIMEOUT  64   idle cycles a locked owner may stall (valid low) before forced release
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            async active-low reset
//  req_valid    in   NREQ         requester i has a flit
//  req_flit     in   flit_t[NREQ] requester flits (yc_noc_defs::flit_t), passed unmodified
//  req_last     in   NREQ         flit i is the packet tail (single-flit packet: first=last)
//  req_ready    out  NREQ         flit i accepted this cycle when req_valid[i]&req_ready[i]
//  tx_valid     out  1            flit to router valid (registered)
//  tx_flit      out  flit_t       flit to router (registered)
//  tx_ready     in   1            router accepts tx_flit
//  owner        out  $clog2(NREQ) current/last granted requester
//  locked       out  1            packet in progress (state LOCKED)
//  err_timeout  out  1            sticky: watchdog forced a release
//  pkt_count    out  16           packets (tails) accepted, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: tx_valid=0, tx_flit='0, req_ready=0, owner=0, locked=0, err_timeout=0,
//   pkt_count=0, rr_ptr=0, wdog=0, state IDLE. Async assert; all state cleared mid-packet.
//  slot_free = !tx_valid | tx_ready. No req_ready asserted unless slot_free.
//  IDLE: winner g = first i with req_valid[i], searching rr_ptr, rr_ptr+1,... mod NREQ.
//   If slot_free & any valid: req_ready[g]=1 (combinational, same cycle), owner<=g.
//   Accepted flit with req_last: stay IDLE, rr_ptr<=(g+1)%NREQ, pkt_count++.
//   Accepted flit without req_last: ->LOCKED, locked<=1, wdog<=0.
//  LOCKED: only req_ready[owner]=slot_free; all others 0 regardless of valid.
//   Accept with req_last: ->IDLE, locked<=0, rr_ptr<=(owner+1)%NREQ, pkt_count++.
//   Accept without last: wdog<=0. Owner valid low: wdog++; stall on !slot_free holds wdog.
//   wdog==LOCK_TIMEOUT-1 and owner valid low: ->IDLE, err_timeout<=1, rr_ptr<=owner+1;
//   no flit emitted, remaining owner flits treated as a new packet later.
//  Datapath: accepted flit loads tx_flit, tx_valid<=1 next cycle (latency 1). If slot_free
//   and no accept, tx_valid<=0. Load and drain in same cycle allowed -> back-to-back flits
//   at full throughput. tx_flit held stable while tx_valid & !tx_ready.
//  Only one req_ready bit high per cycle (onehot0). Flit order per requester preserved.
//  Grants switch only at packet boundaries; no flit interleaving of two packets on tx.
//  tx_ready ignored when tx_valid=0. owner holds value in IDLE until next grant.
// TESTING
//  1 Reset, req0 single flit (last=1) at cycle 5, tx_ready=1 -> req_ready[0] cycle 5,
//    tx_valid cycle 6 with same flit, pkt_count=1, rr_ptr=1.
//  2 All 4 valid, single-flit packets, tx_ready=1 -> grant order 0,1,2,3,0 one per cycle,
//    tx_valid continuous, pkt_count=5 after 5 grants.
//  3 req1 3-flit packet, req2 valid throughout -> req1 flits contiguous on tx, req2 granted
//    only cycle after req1 tail accepted; locked high for exactly 2 cycles.
//  4 tx_ready=0 for 3 cycles mid-packet -> tx_flit stable, req_ready all 0, no loss or dup.
//  5 req0 sends head (last=0), then drops valid for LOCK_TIMEOUT cycles -> err_timeout=1,
//    locked=0, req3 pending valid granted next cycle; pkt_count unchanged.
//  6 rst_n low while LOCKED with tx_valid=1 -> all outputs reset values immediately.

Source files
------------

// File: rtl/yc_niu_inj_arb.sv
// Round-robin, packet-atomic injection arbiter sharing one router local port among NIU sources.
// Registered output stage with lock watchdog and tail-packet counter.
package yc_noc_defs;
  localparam int unsigned VC_W   = 2;
  localparam int unsigned DEST_W = 4;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module yc_niu_inj_arb
  import yc_noc_defs::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned LOCK_TIMEOUT = 64,
  localparam int unsigned IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  flit_t [NREQ-1:0]      req_flit,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  tx_valid,
  output flit_t                 tx_flit,
  input  logic                  tx_ready,
  output logic [IDX_W-1:0]      owner,
  output logic                  locked,
  output logic                  err_timeout,
  output logic [15:0]           pkt_count
);

  localparam int unsigned WDOG_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [IDX_W-1:0]   owner_d;
  logic               locked_d, err_d, tx_valid_d;
  logic [15:0]        pkt_d;
  flit_t              tx_flit_d;
  logic [IDX_W-1:0]   sel;
  logic               accept;
  logic               slot_free_c;
  logic               win_found_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [IDX_W-1:0]   cand;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return IDX_W'((32'(i) + 32'd1) % NREQ);
  endfunction

  assign slot_free_c = !tx_valid || tx_ready;

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NREQ);
      if (!win_found_c && req_valid[cand]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand;
      end
    end
  end

  // Next-state, grant and datapath load
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wdog_d     = wdog_q;
    owner_d    = owner;
    locked_d   = locked;
    err_d      = err_timeout;
    pkt_d      = pkt_count;
    tx_valid_d = tx_valid;
    tx_flit_d  = tx_flit;
    req_ready  = '0;
    sel        = owner;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (slot_free_c && win_found_c) begin
          req_ready[win_idx_c] = 1'b1;
          owner_d              = win_idx_c;
          sel                  = win_idx_c;
          if (req_last[win_idx_c]) begin
            rr_ptr_d = next_idx(win_idx_c);
            pkt_d    = pkt_count + 16'd1;
          end else begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            wdog_d   = '0;
          end
        end
      end
      S_LOCKED: begin
        req_ready[owner] = slot_free_c;
        if (req_valid[owner]) begin
          if (slot_free_c) begin
            wdog_d = '0;
            if (req_last[owner]) begin
              state_d  = S_IDLE;
              locked_d = 1'b0;
              rr_ptr_d = next_idx(owner);
              pkt_d    = pkt_count + 16'd1;
            end
          end
        end else if (wdog_q == WDOG_LIM) begin
          // Owner stalled too long: abandon the packet, rest of it arbitrates as new
          state_d  = S_IDLE;
          locked_d = 1'b0;
          err_d    = 1'b1;
          rr_ptr_d = next_idx(owner);
          wdog_d   = '0;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept = |(req_valid & req_ready);
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_flit_d  = req_flit[sel];
    end else if (slot_free_c) begin
      tx_valid_d = 1'b0;
    end

    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      pkt_count   <= '0;
      tx_valid    <= 1'b0;
      tx_flit     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      owner       <= owner_d;
      locked      <= locked_d;
      err_timeout <= err_d;
      pkt_count   <= pkt_d;
      tx_valid    <= tx_valid_d;
      tx_flit     <= tx_flit_d;
    end
  end

endmodule

// File: tb/tb_yc_niu_inj_arb.sv
// Directed self-checking bench for yc_niu_inj_arb: grant order, packet locking,
// backpressure, watchdog release and asynchronous reset.
module tb_yc_niu_inj_arb;
  import yc_noc_defs::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LOCK_TIMEOUT = 64;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  flit_t [NREQ-1:0] req_flit;
  logic [NREQ-1:0]  req_last;
  logic [NREQ-1:0]  req_ready;
  logic             tx_valid;
  flit_t            tx_flit;
  logic             tx_ready;
  logic [1:0]       owner;
  logic             locked;
  logic             err_timeout;
  logic [15:0]      pkt_count;

  int checks = 0;
  int failures = 0;

  yc_niu_inj_arb #(.NREQ(NREQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_flit(req_flit),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_flit(tx_flit),
    .tx_ready(tx_ready), .owner(owner), .locked(locked), .err_timeout(err_timeout),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic flit_t mk(input int src, input int seq);
    flit_t f;
    f.vc   = 2'(src);
    f.dest = 4'(seq);
    f.data = 32'hA500_0000 | (32'(src) << 8) | 32'(seq);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txv"},   64'(tx_valid), 64'(0));
    chk({tag, "_txf"},   64'(tx_flit), 64'(0));
    chk({tag, "_rdy"},   64'(req_ready), 64'(0));
    chk({tag, "_own"},   64'(owner), 64'(0));
    chk({tag, "_lock"},  64'(locked), 64'(0));
    chk({tag, "_err"},   64'(err_timeout), 64'(0));
    chk({tag, "_pkt"},   64'(pkt_count), 64'(0));
  endtask

  task automatic do_reset();
    req_valid = '0; req_last = '0; req_flit = '0; tx_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b1; req_valid = '0; req_last = '0; req_flit = '0; tx_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_vals("rst0");
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // Test 1: single-flit packet from req0, one-cycle latency
    req_valid = 4'b0001; req_last = 4'b0001; req_flit[0] = mk(0, 1);
    #1 chk("t1_rdy", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    chk("t1_txv", 64'(tx_valid), 64'(1));
    chk("t1_txf", 64'(tx_flit), 64'(mk(0, 1)));
    chk("t1_pkt", 64'(pkt_count), 64'(1));
    // rr_ptr now 1: req1 beats req0
    req_valid = 4'b0011; req_last = 4'b0011; req_flit[0] = mk(0, 2); req_flit[1] = mk(1, 2);
    #1 chk("t1_rr", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    chk("t1_txf2", 64'(tx_flit), 64'(mk(1, 2)));
    chk("t1_own", 64'(owner), 64'(1));

    // Test 2: all valid, single-flit packets, grants 0,1,2,3,0
    do_reset();
    chk_reset_vals("rst2");
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) req_flit[i] = mk(i, k);
      #1 chk("t2_rdy", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("t2_txv", 64'(tx_valid), 64'(1));
      chk("t2_txf", 64'(tx_flit), 64'(mk(k % 4, k)));
      chk("t2_own", 64'(owner), 64'(k % 4));
    end
    chk("t2_pkt", 64'(pkt_count), 64'(5));
    req_valid = '0;
    tick();
    chk("t2_drain", 64'(tx_valid), 64'(0));

    // Test 3: req1 3-flit packet while req2 waits (rr_ptr=1)
    req_valid = 4'b0110; req_last = 4'b0100;
    req_flit[1] = mk(1, 0); req_flit[2] = mk(2, 9);
    #1 chk("t3_rdyA", 64'(req_ready), 64'(4'b0010));
    tick();
    chk("t3_lockA", 64'(locked), 64'(1));
    chk("t3_txfA", 64'(tx_flit), 64'(mk(1, 0)));
    req_flit[1] = mk(1, 1);
    #1 chk("t3_rdyB", 64'(req_ready), 64'(4'b0010));
    tick();
    chk("t3_lockB", 64'(locked), 64'(1));
    chk("t3_txfB", 64'(tx_flit), 64'(mk(1, 1)));
    req_flit[1] = mk(1, 2); req_last = 4'b0110;
    #1 chk("t3_rdyC", 64'(req_ready), 64'(4'b0010));
    tick();
    chk("t3_lockC", 64'(locked), 64'(0));
    chk("t3_txfC", 64'(tx_flit), 64'(mk(1, 2)));
    chk("t3_pktC", 64'(pkt_count), 64'(6));
    req_valid = 4'b0100;
    #1 chk("t3_rdyD", 64'(req_ready), 64'(4'b0100));
    tick();
    chk("t3_txfD", 64'(tx_flit), 64'(mk(2, 9)));
    chk("t3_ownD", 64'(owner), 64'(2));
    chk("t3_pktD", 64'(pkt_count), 64'(7));

    // Test 4: backpressure mid-packet on req3 (rr_ptr=3)
    req_valid = 4'b1000; req_last = 4'b0000; req_flit[3] = mk(3, 0);
    #1 chk("t4_rdy0", 64'(req_ready), 64'(4'b1000));
    tick();
    tx_ready = 1'b0; req_flit[3] = mk(3, 1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_stall_rdy", 64'(req_ready), 64'(0));
      tick();
      chk("t4_stall_txv", 64'(tx_valid), 64'(1));
      chk("t4_stall_txf", 64'(tx_flit), 64'(mk(3, 0)));
    end
    tx_ready = 1'b1;
    #1 chk("t4_rdy1", 64'(req_ready), 64'(4'b1000));
    tick();
    chk("t4_txf1", 64'(tx_flit), 64'(mk(3, 1)));
    req_flit[3] = mk(3, 2); req_last = 4'b1000;
    #1 chk("t4_rdy2", 64'(req_ready), 64'(4'b1000));
    tick();
    chk("t4_txf2", 64'(tx_flit), 64'(mk(3, 2)));
    chk("t4_lock", 64'(locked), 64'(0));
    chk("t4_pkt", 64'(pkt_count), 64'(8));
    req_valid = '0;
    tick();
    chk("t4_drain", 64'(tx_valid), 64'(0));

    // Test 5: req0 head then silence -> watchdog release, req3 next
    req_valid = 4'b0001; req_last = 4'b0000; req_flit[0] = mk(0, 5);
    #1 chk("t5_rdy0", 64'(req_ready), 64'(4'b0001));
    tick();
    chk("t5_lock", 64'(locked), 64'(1));
    req_valid = 4'b1000; req_last = 4'b1000; req_flit[3] = mk(3, 7);
    for (int i = 0; i < int'(LOCK_TIMEOUT); i++) begin
      #1;
      if (i == int'(LOCK_TIMEOUT) - 1) begin
        chk("t5_still_lock", 64'(locked), 64'(1));
        chk("t5_no_err_yet", 64'(err_timeout), 64'(0));
      end
      chk("t5_req3_blocked", 64'(req_ready[3]), 64'(0));
      tick();
    end
    chk("t5_unlock", 64'(locked), 64'(0));
    chk("t5_err", 64'(err_timeout), 64'(1));
    chk("t5_pkt", 64'(pkt_count), 64'(8));
    chk("t5_noflit", 64'(tx_valid), 64'(0));
    #1 chk("t5_rdy3", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    chk("t5_txf3", 64'(tx_flit), 64'(mk(3, 7)));
    chk("t5_own3", 64'(owner), 64'(3));
    chk("t5_pkt3", 64'(pkt_count), 64'(9));

    // Test 6: async reset while locked with a flit in the output stage
    req_valid = 4'b0010; req_last = 4'b0000; req_flit[1] = mk(1, 3);
    #1 chk("t6_rdy", 64'(req_ready), 64'(4'b0010));
    tick();
    chk("t6_lock", 64'(locked), 64'(1));
    chk("t6_txv", 64'(tx_valid), 64'(1));
    tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst6");
    tick();
    tx_ready = 1'b1; req_last = 4'b0010; req_flit[1] = mk(1, 4);
    rst_n = 1'b1;
    #1 chk("t6_post_rdy", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    chk("t6_post_txf", 64'(tx_flit), 64'(mk(1, 4)));
    chk("t6_post_pkt", 64'(pkt_count), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
